// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three buses around the data-memory arbiter.
//   CPU side  : enable, cpu_addr, cpu_ren, cpu_wen, cpu_wdata -> cpu_rdata, cpu_stall
//   Host side : host_req, host_wen, host_addr, host_wdata -> host_gnt, host_rvalid, host_rdata
//   Memory    : mem_addr, mem_ren, mem_wen, mem_wdata <- mem_rdata
// Modports:
//   slave  - the arbiter's view (drives grants, stall, read data and memory port)
//   master - the surrounding system's view (pipeline, host and memory model)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic              enable;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_ren;
   logic              cpu_wen;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              host_req;
   logic              host_wen;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ren;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  enable, cpu_addr, cpu_ren, cpu_wen, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  host_req, host_wen, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata,
      output mem_addr, mem_ren, mem_wen, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output enable, cpu_addr, cpu_ren, cpu_wen, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output host_req, host_wen, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata,
      input  mem_addr, mem_ren, mem_wen, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage and an
// external host. The CPU wins by default; a host that has been denied
// STARVE_MAX consecutive cycles is forced through, stalling the CPU. Read data
// (one cycle late from the memory) is steered back to whoever issued the read.
//
// Ports:
//   clk     - single clock, rising edge
//   arst_n  - synchronous active-low reset
//   bus     - dmem_arbiter_if.slave (CPU, host and memory buses)
//   perf_stall_cnt [31:0] - only with DMEM_ARB_PERF_EN: saturating count of
//                           cycles with cpu_stall = 1
//
// Optional feature macro: DMEM_ARB_PERF_EN (stall performance counter).
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 64,
   parameter int STARVE_MAX = 8
) (
   input  logic                 clk,
   input  logic                 arst_n,
   dmem_arbiter_if.slave        bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]          perf_stall_cnt
`endif
);

   localparam logic [1:0] RD_IDLE = 2'b00;
   localparam logic [1:0] RD_CPU  = 2'b01;
   localparam logic [1:0] RD_HOST = 2'b10;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic       cpu_act_s;
   logic       host_act_s;
   logic       cpu_win_s;
   logic       host_win_s;
   logic [7:0] starve_cnt_r;
   logic [7:0] starve_cnt_nxt_s;
   logic [1:0] rd_owner_r;
   logic [1:0] rd_owner_nxt_s;

   // Request decode and same-cycle grant; everything is suppressed while in reset.
   always_comb begin
      cpu_act_s  = bus.enable & (bus.cpu_ren | bus.cpu_wen);
      host_act_s = bus.host_req;
      host_win_s = arst_n & host_act_s & (~cpu_act_s | (starve_cnt_r == STARVE_LIM));
      cpu_win_s  = arst_n & cpu_act_s & ~host_win_s;
      bus.host_gnt  = host_win_s;
      bus.cpu_stall = cpu_act_s & host_win_s;
   end

   // Memory port mux; a CPU write overrides a simultaneous CPU read.
   always_comb begin
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};
      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 1'b0;
      if (host_win_s) begin
         bus.mem_addr  = bus.host_addr;
         bus.mem_wdata = bus.host_wdata;
         bus.mem_ren   = ~bus.host_wen;
         bus.mem_wen   = bus.host_wen;
      end else if (cpu_win_s) begin
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
         bus.mem_ren   = bus.cpu_ren & ~bus.cpu_wen;
         bus.mem_wen   = bus.cpu_wen;
      end else begin
         bus.mem_addr  = {ADDR_W{1'b0}};
         bus.mem_wdata = {DATA_W{1'b0}};
         bus.mem_ren   = 1'b0;
         bus.mem_wen   = 1'b0;
      end
   end

   // Next-state for the starvation counter and the read-return owner.
   always_comb begin
      starve_cnt_nxt_s = starve_cnt_r;
      rd_owner_nxt_s   = RD_IDLE;
      if (host_win_s | ~host_act_s) begin
         starve_cnt_nxt_s = 8'd0;
      end else if (starve_cnt_r == STARVE_LIM) begin
         starve_cnt_nxt_s = starve_cnt_r;
      end else begin
         starve_cnt_nxt_s = starve_cnt_r + 8'd1;
      end
      if (cpu_win_s & bus.cpu_ren & ~bus.cpu_wen) begin
         rd_owner_nxt_s = RD_CPU;
      end else if (host_win_s & ~bus.host_wen) begin
         rd_owner_nxt_s = RD_HOST;
      end else begin
         rd_owner_nxt_s = RD_IDLE;
      end
   end

   // State registers; reset drops any in-flight read.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         starve_cnt_r <= 8'd0;
         rd_owner_r   <= RD_IDLE;
      end else begin
         starve_cnt_r <= starve_cnt_nxt_s;
         rd_owner_r   <= rd_owner_nxt_s;
      end
   end

   // Steer the late read data to the requester recorded last cycle.
   always_comb begin
      bus.cpu_rdata   = {DATA_W{1'b0}};
      bus.host_rdata  = {DATA_W{1'b0}};
      bus.host_rvalid = 1'b0;
      case (rd_owner_r)
         RD_CPU: begin
            bus.cpu_rdata = bus.mem_rdata;
         end
         RD_HOST: begin
            bus.host_rdata  = bus.mem_rdata;
            bus.host_rvalid = 1'b1;
         end
         default: begin
            bus.cpu_rdata   = {DATA_W{1'b0}};
            bus.host_rdata  = {DATA_W{1'b0}};
            bus.host_rvalid = 1'b0;
         end
      endcase
   end

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall_cnt_r;

   // Saturating count of cycles in which the CPU lost the memory port.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         perf_stall_cnt_r <= 32'd0;
      end else if (bus.cpu_stall && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
         perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
      end else begin
         perf_stall_cnt_r <= perf_stall_cnt_r;
      end
   end

   assign perf_stall_cnt = perf_stall_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small registered-read memory model.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 time
// units after the edge, well away from the next one.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic clk;
   logic arst_n;
   int   n_checks;
   int   n_fail;

   dmem_arbiter_if #(.DATA_W(64), .ADDR_W(64)) bus ();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_cnt;
`endif

   dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .STARVE_MAX(8)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_stall_cnt (perf_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: write on the edge, registered read with 1-cycle latency.
   logic [63:0] mem_model [0:255];
   always @(posedge clk) begin
      if (bus.mem_wen) mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_ren) bus.mem_rdata <= mem_model[bus.mem_addr[7:0]];
   end

   task automatic set_idle();
      bus.enable     = 1'b1;
      bus.cpu_addr   = 64'd0;
      bus.cpu_ren    = 1'b0;
      bus.cpu_wen    = 1'b0;
      bus.cpu_wdata  = 64'd0;
      bus.host_req   = 1'b0;
      bus.host_wen   = 1'b0;
      bus.host_addr  = 64'd0;
      bus.host_wdata = 64'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      bus.enable = 1'b1; bus.cpu_ren = 1'b1; bus.cpu_addr = 64'h10;
      bus.host_req = 1'b1; bus.host_addr = 64'h20;
      #1;
      n_checks++;
      if ({bus.host_gnt, bus.cpu_stall, bus.mem_ren, bus.mem_wen} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0000",
                  {bus.host_gnt, bus.cpu_stall, bus.mem_ren, bus.mem_wen});
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.host_rvalid, bus.cpu_rdata, bus.host_rdata} !== {1'b0, 64'd0, 64'd0}) begin
         n_fail++;
         $display("FAIL reset_rdata: got rvalid=%b cpu=%h host=%h expected 0/0/0",
                  bus.host_rvalid, bus.cpu_rdata, bus.host_rdata);
      end
      arst_n = 1'b1;
      set_idle();
   endtask

   task automatic test_host_write();
      bus.enable = 1'b0;
      bus.host_req = 1'b1; bus.host_wen = 1'b1;
      bus.host_addr = 64'h10; bus.host_wdata = 64'hAB;
      #1;
      n_checks++;
      if ({bus.host_gnt, bus.mem_wen, bus.mem_ren} !== 3'b110 || bus.mem_wdata !== 64'hAB) begin
         n_fail++;
         $display("FAIL host_write: got gnt/wen/ren=%b wdata=%h expected 110 wdata=ab",
                  {bus.host_gnt, bus.mem_wen, bus.mem_ren}, bus.mem_wdata);
      end
      next_cycle();
      bus.host_addr = 64'h20; bus.host_wdata = 64'h55;
      #1;
      n_checks++;
      if (bus.host_gnt !== 1'b1 || bus.mem_addr !== 64'h20 || bus.host_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL host_write2: got gnt=%b addr=%h rvalid=%b expected 1/20/0",
                  bus.host_gnt, bus.mem_addr, bus.host_rvalid);
      end
      next_cycle();
      set_idle();
   endtask

   task automatic test_cpu_only();
      bus.cpu_ren = 1'b1; bus.cpu_addr = 64'h10;
      #1;
      n_checks++;
      if ({bus.mem_ren, bus.mem_wen, bus.cpu_stall, bus.host_gnt} !== 4'b1000 ||
          bus.mem_addr !== 64'h10) begin
         n_fail++;
         $display("FAIL cpu_only_issue: got ren/wen/stall/gnt=%b addr=%h expected 1000 addr=10",
                  {bus.mem_ren, bus.mem_wen, bus.cpu_stall, bus.host_gnt}, bus.mem_addr);
      end
      next_cycle();
      set_idle();
      n_checks++;
      if (bus.cpu_rdata !== 64'hAB || bus.host_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL cpu_only_rdata: got %h rvalid=%b expected ab rvalid=0",
                  bus.cpu_rdata, bus.host_rvalid);
      end
   endtask

   task automatic test_host_only();
      bus.enable = 1'b0; bus.cpu_ren = 1'b1; bus.cpu_addr = 64'h10;
      bus.host_req = 1'b1; bus.host_wen = 1'b0; bus.host_addr = 64'h20;
      #1;
      n_checks++;
      if ({bus.host_gnt, bus.cpu_stall, bus.mem_ren} !== 3'b101 || bus.mem_addr !== 64'h20) begin
         n_fail++;
         $display("FAIL host_only_issue: got gnt/stall/ren=%b addr=%h expected 101 addr=20",
                  {bus.host_gnt, bus.cpu_stall, bus.mem_ren}, bus.mem_addr);
      end
      next_cycle();
      set_idle();
      n_checks++;
      if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 64'h55 || bus.cpu_rdata !== 64'd0) begin
         n_fail++;
         $display("FAIL host_only_rdata: got rvalid=%b host=%h cpu=%h expected 1/55/0",
                  bus.host_rvalid, bus.host_rdata, bus.cpu_rdata);
      end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_gs;
      logic [63:0] exp_addr;
      bus.enable = 1'b1; bus.cpu_ren = 1'b1; bus.cpu_addr = 64'h10;
      bus.host_req = 1'b1; bus.host_wen = 1'b0; bus.host_addr = 64'h20;
      for (int c = 1; c <= 10; c++) begin
         exp_gs   = (c == 9) ? 2'b11 : 2'b00;
         exp_addr = (c == 9) ? 64'h20 : 64'h10;
         #1;
         n_checks++;
         if ({bus.host_gnt, bus.cpu_stall} !== exp_gs || bus.mem_addr !== exp_addr ||
             bus.mem_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_c%0d: got gnt/stall=%b addr=%h ren=%b expected %b addr=%h ren=1",
                     c, {bus.host_gnt, bus.cpu_stall}, bus.mem_addr, bus.mem_ren, exp_gs, exp_addr);
         end
         if (c == 10) begin
            n_checks++;
            if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 64'h55 || bus.cpu_rdata !== 64'd0) begin
               n_fail++;
               $display("FAIL contention_host_ret: got rvalid=%b host=%h cpu=%h expected 1/55/0",
                        bus.host_rvalid, bus.host_rdata, bus.cpu_rdata);
            end
         end else if (c >= 2) begin
            n_checks++;
            if (bus.cpu_rdata !== 64'hAB || bus.host_rvalid !== 1'b0) begin
               n_fail++;
               $display("FAIL contention_cpu_ret_c%0d: got %h rvalid=%b expected ab rvalid=0",
                        c, bus.cpu_rdata, bus.host_rvalid);
            end
         end
         next_cycle();
      end
      set_idle();
      n_checks++;
      if (bus.cpu_rdata !== 64'hAB) begin
         n_fail++;
         $display("FAIL contention_last_ret: got %h expected ab", bus.cpu_rdata);
      end
      next_cycle();
   endtask

   task automatic test_write_read();
      bus.cpu_wen = 1'b1; bus.cpu_addr = 64'h30; bus.cpu_wdata = 64'h1234;
      #1;
      n_checks++;
      if ({bus.mem_wen, bus.mem_ren, bus.cpu_stall} !== 3'b100 || bus.mem_wdata !== 64'h1234) begin
         n_fail++;
         $display("FAIL wr_issue: got wen/ren/stall=%b wdata=%h expected 100 wdata=1234",
                  {bus.mem_wen, bus.mem_ren, bus.cpu_stall}, bus.mem_wdata);
      end
      next_cycle();
      bus.cpu_wen = 1'b0;
      bus.host_req = 1'b1; bus.host_wen = 1'b0; bus.host_addr = 64'h30;
      #1;
      n_checks++;
      if (bus.host_gnt !== 1'b1 || bus.mem_addr !== 64'h30 || bus.cpu_rdata !== 64'd0) begin
         n_fail++;
         $display("FAIL wr_host_issue: got gnt=%b addr=%h cpu_rdata=%h expected 1/30/0",
                  bus.host_gnt, bus.mem_addr, bus.cpu_rdata);
      end
      next_cycle();
      bus.host_req = 1'b0;
      bus.cpu_ren = 1'b1; bus.cpu_wen = 1'b1; bus.cpu_addr = 64'h40; bus.cpu_wdata = 64'h77;
      #1;
      n_checks++;
      if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 64'h1234) begin
         n_fail++;
         $display("FAIL wr_host_rdata: got rvalid=%b data=%h expected 1/1234",
                  bus.host_rvalid, bus.host_rdata);
      end
      n_checks++;
      if ({bus.mem_wen, bus.mem_ren} !== 2'b10) begin
         n_fail++;
         $display("FAIL rw_both_precedence: got wen/ren=%b expected 10", {bus.mem_wen, bus.mem_ren});
      end
      next_cycle();
      set_idle();
      n_checks++;
      if (bus.cpu_rdata !== 64'd0 || bus.host_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_both_no_ret: got cpu=%h rvalid=%b expected 0/0",
                  bus.cpu_rdata, bus.host_rvalid);
      end
   endtask

   task automatic test_back_to_back();
      bus.cpu_ren = 1'b1; bus.cpu_addr = 64'h10;
      next_cycle();
      bus.cpu_ren = 1'b0;
      bus.host_req = 1'b1; bus.host_wen = 1'b0; bus.host_addr = 64'h20;
      #1;
      n_checks++;
      if (bus.cpu_rdata !== 64'hAB || bus.host_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_1: got cpu=%h gnt=%b expected ab/1", bus.cpu_rdata, bus.host_gnt);
      end
      next_cycle();
      bus.host_req = 1'b0;
      bus.cpu_ren = 1'b1; bus.cpu_addr = 64'h30;
      #1;
      n_checks++;
      if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 64'h55 || bus.cpu_rdata !== 64'd0) begin
         n_fail++;
         $display("FAIL b2b_2: got rvalid=%b host=%h cpu=%h expected 1/55/0",
                  bus.host_rvalid, bus.host_rdata, bus.cpu_rdata);
      end
      next_cycle();
      set_idle();
      n_checks++;
      if (bus.cpu_rdata !== 64'h1234 || bus.host_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_3: got cpu=%h rvalid=%b expected 1234/0", bus.cpu_rdata, bus.host_rvalid);
      end
   endtask

   task automatic test_reset_mid_read();
      bus.enable = 1'b0;
      bus.host_req = 1'b1; bus.host_wen = 1'b0; bus.host_addr = 64'h20;
      #1;
      n_checks++;
      if (bus.host_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_read_gnt: got %b expected 1", bus.host_gnt);
      end
      #1;
      arst_n = 1'b0;
      bus.enable = 1'b1; bus.cpu_ren = 1'b1; bus.cpu_addr = 64'h10;
      #1;
      n_checks++;
      if ({bus.host_gnt, bus.cpu_stall, bus.mem_ren, bus.mem_wen} !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_read_ctrl: got %b expected 0000",
                  {bus.host_gnt, bus.cpu_stall, bus.mem_ren, bus.mem_wen});
      end
      next_cycle();
      n_checks++;
      if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 64'd0 || bus.cpu_rdata !== 64'd0) begin
         n_fail++;
         $display("FAIL mid_read_dropped: got rvalid=%b host=%h cpu=%h expected 0/0/0",
                  bus.host_rvalid, bus.host_rdata, bus.cpu_rdata);
      end
      next_cycle();
      n_checks++;
      if (dut.starve_cnt_r !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_read_starve: got %0d expected 0", dut.starve_cnt_r);
      end
      arst_n = 1'b1;
      set_idle();
      next_cycle();
   endtask

`ifdef DMEM_ARB_PERF_EN
   task automatic test_perf();
      n_checks++;
      if (perf_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got %0d expected 0", perf_cnt);
      end
      test_contention();
      test_contention();
      n_checks++;
      if (perf_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL perf_count: got %0d expected 2", perf_cnt);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      arst_n   = 1'b0;
      set_idle();
      test_reset();
      test_host_write();
      test_cpu_only();
      test_host_only();
      test_contention();
      test_write_read();
      test_back_to_back();
      test_reset_mid_read();
`ifdef DMEM_ARB_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
